// File: rtl/wallace_mac_pipe_if.sv
// Handshake/data bundle between a producer/consumer and wallace_mac_pipe.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
// Ports: in_valid, in_ready, a, b, mode, acc_clr, out_valid, out_ready, y.
interface wallace_mac_pipe_if #(
    parameter int W = 8,
    parameter int G = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [1:0]        mode;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic [2*W+G-1:0]  y;

    // master: the side that issues transactions and consumes results
    modport master (
        output in_valid, a, b, mode, acc_clr, out_ready,
        input  in_ready, out_valid, y
    );

    // slave: the multiply-accumulate block
    modport slave (
        input  in_valid, a, b, mode, acc_clr, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/wallace_mac_pipe.sv
// Pipelined Wallace-tree multiplier / multiply-accumulator (unsigned or Baugh-Wooley signed).
// Latency: 3 register stages (S1 partial products + early CSA layers, S2 CSA to two rows, S3 CPA + acc).
// Backpressure: whole pipe stalls together when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport of wallace_mac_pipe_if).
module wallace_mac_pipe #(
    parameter int W = 8,
    parameter int G = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wallace_mac_pipe_if.slave bus
);
    localparam int PW = 2 * W;
    localparam int YW = PW + G;
    localparam int R  = W + 1;      // W partial-product rows + one Baugh-Wooley constant row

    typedef logic [R-1:0][PW-1:0] rows_t;

    // Live row count after k layers of 3:2 compression (a partial group of 1 or 2 rows
    // produces as many live rows as it had).
    function automatic int live_after(input int n0, input int k);
        int n;
        n = n0;
        for (int i = 0; i < k; i++) begin
            if (n > 2) n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int layers_to_two(input int n0);
        int n;
        int cnt;
        n   = n0;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n   = 2 * (n / 3) + n % 3;
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    localparam int NL  = layers_to_two(R);
    localparam int NL1 = (NL + 1) / 2;          // layers done in S1
    localparam int NL2 = NL - NL1;              // layers done in S2
    localparam int L1  = live_after(R, NL1);    // rows registered between S1 and S2

    // One Wallace layer: every group of three rows becomes sum + shifted carry.
    // Live rows stay packed at the low indices; unused rows are zero.
    function automatic rows_t csa_layer(input rows_t r);
        rows_t o;
        o = '0;
        for (int g = 0; g < R / 3; g++) begin
            o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
        end
        for (int k = 0; k < R % 3; k++) begin
            o[2*(R/3)+k] = r[3*(R/3)+k];
        end
        return o;
    endfunction

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- S1: partial products + first reduction layers ----------------
    rows_t pp;
    rows_t red1;
    logic  sgn;
    assign sgn = bus.mode[0];

    always_comb begin
        pp = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                // Baugh-Wooley: terms pairing exactly one sign bit are complemented
                pp[i][i+j] = (bus.a[j] & bus.b[i]) ^ (sgn & ((i == W-1) != (j == W-1)));
            end
        end
        if (sgn) begin
            pp[W][W]    = 1'b1;     // correction constant 2^W + 2^(2W-1)
            pp[W][PW-1] = 1'b1;
        end
        red1 = pp;
        for (int l = 0; l < NL1; l++) begin
            red1 = csa_layer(red1);
        end
    end

    logic                   s1_vld;
    logic [L1-1:0][PW-1:0]  s1_rows;
    logic [1:0]             s1_mode;
    logic                   s1_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_rows <= '0;
            s1_mode <= '0;
            s1_clr  <= 1'b0;
        end else if (adv) begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                s1_rows <= red1[L1-1:0];
                s1_mode <= bus.mode;
                s1_clr  <= bus.acc_clr;
            end
        end
    end

    // ---------------- S2: reduce to two rows ----------------
    rows_t red2;

    always_comb begin
        red2         = '0;
        red2[L1-1:0] = s1_rows;
        for (int l = 0; l < NL2; l++) begin
            red2 = csa_layer(red2);
        end
    end

    logic          s2_vld;
    logic [PW-1:0] s2_sum;
    logic [PW-1:0] s2_car;
    logic [1:0]    s2_mode;
    logic          s2_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sum  <= '0;
            s2_car  <= '0;
            s2_mode <= '0;
            s2_clr  <= 1'b0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sum  <= red2[0];
                s2_car  <= red2[1];
                s2_mode <= s1_mode;
                s2_clr  <= s1_clr;
            end
        end
    end

    // ---------------- S3: carry-propagate add + accumulate ----------------
    logic [PW-1:0] prod;
    logic [YW-1:0] prod_ext;
    logic [YW-1:0] acc_base;
    logic [YW-1:0] acc_nxt;
    logic [YW-1:0] y_nxt;
    logic [YW-1:0] acc;
    logic [YW-1:0] y_reg;
    logic          out_vld;

    always_comb begin
        prod     = s2_sum + s2_car;
        prod_ext = s2_mode[0] ? YW'($signed(prod)) : YW'(prod);
        acc_base = s2_clr ? '0 : acc;
        acc_nxt  = s2_mode[1] ? acc_base + prod_ext : acc_base;  // wraps silently
        y_nxt    = s2_mode[1] ? acc_nxt : prod_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            acc     <= '0;
            y_reg   <= '0;
        end else if (adv) begin
            out_vld <= s2_vld;
            if (s2_vld) begin
                acc   <= acc_nxt;
                y_reg <= y_nxt;
            end
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.y         = y_reg;

endmodule

// File: tb/tb_wallace_mac_pipe.sv
// Scoreboard bench for wallace_mac_pipe (W=8, G=4): directed vectors, stall, reset, random.
// Latency: checks 3-edge input-to-output latency on the first transaction.
// Backpressure: out_ready forced low mid-stream and randomised during the regression.
module tb_wallace_mac_pipe;
    localparam int W  = 8;
    localparam int G  = 4;
    localparam int YW = 2 * W + G;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wallace_mac_pipe_if #(.W(W), .G(G)) bus ();
    wallace_mac_pipe #(.W(W), .G(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int            n_vec = 0;
    int            n_err = 0;
    logic [YW-1:0] exp_q[$];
    logic [YW-1:0] model_acc;
    bit            rdy_rand  = 1'b0;
    bit            rdy_force = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to the result width.
    function automatic logic [YW-1:0] model_step(input logic [1:0] m, input logic [W-1:0] x,
                                                 input logic [W-1:0] z, input logic clr);
        longint        sx;
        longint        sz;
        longint        p;
        logic [YW-1:0] prod;
        logic [YW-1:0] base;
        sx = longint'(x);
        sz = longint'(z);
        if (m[0]) begin
            if (x[W-1]) sx = sx - (longint'(1) << W);
            if (z[W-1]) sz = sz - (longint'(1) << W);
        end
        p    = sx * sz;
        prod = p[YW-1:0];
        base = clr ? '0 : model_acc;
        if (m[1]) begin
            model_acc = base + prod;
            return model_acc;
        end
        model_acc = base;
        return prod;
    endfunction

    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_out", 64'(bus.y), 64'h0 - 1);
            else                   chk("y", 64'(bus.y), 64'(exp_q.pop_front()));
        end
    end

    // Enters and leaves just after a rising edge.
    task automatic send(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] z,
                        input logic clr, input bit use_exp = 1'b0, input logic [YW-1:0] ev = '0);
        int            guard;
        bit            done;
        logic [YW-1:0] mexp;
        guard       = 0;
        done        = 1'b0;
        bus.mode    = m;
        bus.a       = x;
        bus.b       = z;
        bus.acc_clr = clr;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                mexp = model_step(m, x, z, clr);
                exp_q.push_back(use_exp ? ev : mexp);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 1000) begin
                    chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (exp_q.size() != 0 && g < 500);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [YW-1:0] yhold;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.mode     = '0;
        bus.acc_clr  = 1'b0;
        model_acc    = '0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_y",         64'(bus.y),         64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after release accepts; result after the third edge.
        send(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b1, 20'h0FE01);
        @(negedge clk); chk("lat_edge1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("lat_edge2", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("lat_edge3", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        send(2'b01, 8'h80, 8'h80, 1'b0, 1'b1, 20'h04000);
        send(2'b01, 8'hFF, 8'h01, 1'b0, 1'b1, 20'hFFFFF);
        send(2'b10, 8'd3,  8'd4,  1'b1, 1'b1, 20'd12);
        send(2'b10, 8'd5,  8'd6,  1'b0, 1'b1, 20'd42);
        send(2'b10, 8'hFF, 8'hFF, 1'b0, 1'b1, 20'h0FE2B);
        send(2'b11, 8'hFF, 8'h02, 1'b1, 1'b1, 20'hFFFFE);
        drain();

        // Six back-to-back transactions with a 4-cycle output stall.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'(i % 4), 8'($urandom), 8'($urandom), 1'(i == 0));
            end
            begin
                repeat (4) @(posedge clk);
                rdy_force = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
                    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    if (k > 0) chk("stall_y_hold", 64'(bus.y), 64'(yhold));
                    yhold = bus.y;
                end
                rdy_force = 1'b1;
            end
        join
        drain();

        // Reset with two MAC transactions in flight.
        send(2'b10, 8'd7, 8'd9, 1'b1);
        send(2'b10, 8'd5, 8'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_y",         64'(bus.y),         64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        exp_q.delete();
        model_acc = '0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        send(2'b10, 8'd2, 8'd3, 1'b0, 1'b1, 20'd6);
        drain();

        // Random regression with random gaps and random back-pressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 1));
        end
        drain();
        rdy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
